// File: rtl/bg_palette_fader.sv
// -----------------------------------------------------------------------------
// bg_palette_fader
//
// Sequences a level-to-level background palette change: on an accepted request
// the current palette fades to black over whole frames, the palette mux select
// switches to the requested palette, and the new palette fades back in.
// Also scales the muxed palette colour by the current brightness.
//
// Ports:
//   clk        pixel clock, all logic on the rising edge
//   reset_n    asynchronous active-low reset
//   frame_tick one-cycle pulse per frame (start of vertical blank)
//   req        level-change request, sampled every cycle
//   level_sel  target palette, valid with req
//   rgb_in     {r,g,b} 4 bits each, from the palette selected by pal_sel
//   blank_in   1 = active video, 0 = blanking
//   pal_sel    palette mux select
//   rgb_out    brightness-scaled colour, registered (1-cycle latency)
//   busy       high whenever a transition is in progress
//   done       one-cycle pulse when a transition completes
//   req_err    one-cycle pulse when a request names a nonexistent palette
//   bright     current brightness, 0..15
// -----------------------------------------------------------------------------
module bg_palette_fader #(
    parameter int NUM_PAL         = 4,
    parameter int SEL_W           = $clog2(NUM_PAL),
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frame_tick,
    input  logic             req,
    input  logic [SEL_W-1:0] level_sel,
    input  logic [11:0]      rgb_in,
    input  logic             blank_in,
    output logic [SEL_W-1:0] pal_sel,
    output logic [11:0]      rgb_out,
    output logic             busy,
    output logic             done,
    output logic             req_err,
    output logic [3:0]       bright
);

    // Counter is at least one bit wide so FRAMES_PER_STEP=1 still elaborates.
    localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAMES_PER_STEP - 1);
    // One extra bit so NUM_PAL itself is representable for the range check.
    localparam logic [SEL_W:0]   NUM_PAL_W = (SEL_W + 1)'(NUM_PAL);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        SWAP     = 2'd2,
        FADE_IN  = 2'd3
    } state_t;

    state_t           state_reg;
    logic [SEL_W-1:0] pal_sel_reg;
    logic [SEL_W-1:0] target_reg;
    logic [3:0]       bright_reg;
    logic [CNT_W-1:0] frame_cnt_reg;
    logic             done_reg;
    logic             req_err_reg;
    logic [11:0]      rgb_out_reg;

    logic             level_ok;
    logic             fading;
    logic             step;
    logic [11:0]      rgb_next;

    assign level_ok = ({1'b0, level_sel} < NUM_PAL_W);
    assign fading   = (state_reg == FADE_OUT) || (state_reg == FADE_IN);
    // A step is the frame tick that completes FRAMES_PER_STEP frames.
    assign step     = fading && frame_tick && (frame_cnt_reg == CNT_LAST);

    // -------------------------------------------------------------------------
    // Transition state machine
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            pal_sel_reg   <= '0;
            target_reg    <= '0;
            bright_reg    <= 4'd15;
            frame_cnt_reg <= '0;
            done_reg      <= 1'b0;
            req_err_reg   <= 1'b0;
        end else begin
            done_reg    <= 1'b0;
            req_err_reg <= 1'b0;

            // Frame counting only while fading; IDLE ticks (including one that
            // coincides with an accepted request) are not counted.
            if (fading && frame_tick) begin
                if (frame_cnt_reg == CNT_LAST) begin
                    frame_cnt_reg <= '0;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (req) begin
                        if (level_ok) begin
                            target_reg    <= level_sel;
                            frame_cnt_reg <= '0;
                            state_reg     <= FADE_OUT;
                        end else begin
                            req_err_reg <= 1'b1;
                        end
                    end
                end
                FADE_OUT: begin
                    if (step) begin
                        bright_reg <= bright_reg - 4'd1;
                        if (bright_reg == 4'd1) begin
                            state_reg <= SWAP;
                        end
                    end
                end
                SWAP: begin
                    pal_sel_reg   <= target_reg;
                    frame_cnt_reg <= '0;
                    state_reg     <= FADE_IN;
                end
                FADE_IN: begin
                    if (step) begin
                        bright_reg <= bright_reg + 4'd1;
                        if (bright_reg == 4'd14) begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Colour path: each channel scaled by (bright+1)/16, so bright=15 is a
    // pass-through and bright=0 maps every value below 16 to 0.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        logic [7:0] chan_ext;
        logic [7:0] scale_ext;
        logic [7:0] prod;

        assign chan_ext  = {4'b0000, rgb_in[gi*4 +: 4]};
        assign scale_ext = {4'b0000, bright_reg} + 8'd1;
        assign prod      = chan_ext * scale_ext;
        assign rgb_next[gi*4 +: 4] = 4'(prod >> 4);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_out_reg <= '0;
        end else if (blank_in) begin
            rgb_out_reg <= rgb_next;
        end else begin
            rgb_out_reg <= '0;
        end
    end

    assign pal_sel = pal_sel_reg;
    assign rgb_out = rgb_out_reg;
    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;
    assign req_err = req_err_reg;
    assign bright  = bright_reg;

endmodule

// File: tb/tb_bg_palette_fader.sv
// -----------------------------------------------------------------------------
// tb_bg_palette_fader
//
// Directed bench for bg_palette_fader. Instance a: NUM_PAL=4, FRAMES_PER_STEP=1
// (full transition, colour scaling, blanking, ignored request, async reset).
// Instance b: NUM_PAL=5, FRAMES_PER_STEP=2 (out-of-range request, request and
// frame tick in the same cycle).
// -----------------------------------------------------------------------------
module tb_bg_palette_fader;

    logic        clk;
    logic        reset_n;

    // instance a
    logic        frame_tick_a, req_a, blank_a;
    logic [1:0]  level_a;
    logic [11:0] rgb_in_a;
    logic [1:0]  pal_sel_a;
    logic [11:0] rgb_out_a;
    logic        busy_a, done_a, req_err_a;
    logic [3:0]  bright_a;

    // instance b
    logic        frame_tick_b, req_b, blank_b;
    logic [2:0]  level_b;
    logic [11:0] rgb_in_b;
    logic [2:0]  pal_sel_b;
    logic [11:0] rgb_out_b;
    logic        busy_b, done_b, req_err_b;
    logic [3:0]  bright_b;

    int n_cmp;
    int n_err;
    int done_cnt_a;
    int req_err_cnt_a;

    bg_palette_fader #(.NUM_PAL(4), .FRAMES_PER_STEP(1)) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick_a),
        .req        (req_a),
        .level_sel  (level_a),
        .rgb_in     (rgb_in_a),
        .blank_in   (blank_a),
        .pal_sel    (pal_sel_a),
        .rgb_out    (rgb_out_a),
        .busy       (busy_a),
        .done       (done_a),
        .req_err    (req_err_a),
        .bright     (bright_a)
    );

    bg_palette_fader #(.NUM_PAL(5), .FRAMES_PER_STEP(2)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick_b),
        .req        (req_b),
        .level_sel  (level_b),
        .rgb_in     (rgb_in_b),
        .blank_in   (blank_b),
        .pal_sel    (pal_sel_b),
        .rgb_out    (rgb_out_b),
        .busy       (busy_b),
        .done       (done_b),
        .req_err    (req_err_b),
        .bright     (bright_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic step_clk;
        @(posedge clk);
        #1;
        if (done_a)    done_cnt_a++;
        if (req_err_a) req_err_cnt_a++;
    endtask

    task automatic tick_a;
        frame_tick_a = 1'b1;
        step_clk();
        frame_tick_a = 1'b0;
    endtask

    task automatic tick_b;
        frame_tick_b = 1'b1;
        step_clk();
        frame_tick_b = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; done_cnt_a = 0; req_err_cnt_a = 0;
        reset_n = 1'b0;
        frame_tick_a = 0; req_a = 0; level_a = 0; rgb_in_a = 12'hF84; blank_a = 1;
        frame_tick_b = 0; req_b = 0; level_b = 0; rgb_in_b = 12'hFFF; blank_b = 1;

        // ---------------- reset state ----------------
        #12;
        check_val("rst_rgb_out", 32'(rgb_out_a), 32'h000);
        check_val("rst_bright",  32'(bright_a),  32'd15);
        check_val("rst_pal_sel", 32'(pal_sel_a), 32'd0);
        check_val("rst_busy",    32'(busy_a),    32'd0);
        check_val("rst_done",    32'(done_a),    32'd0);
        check_val("rst_req_err", 32'(req_err_a), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        step_clk();
        check_val("pass_through", 32'(rgb_out_a), 32'hF84);

        // ---------------- transition to palette 2 ----------------
        req_a = 1; level_a = 2'd2;
        step_clk();
        req_a = 0;
        check_val("accept_busy",   32'(busy_a),   32'd1);
        check_val("accept_bright", 32'(bright_a), 32'd15);

        for (int i = 1; i <= 15; i++) begin
            tick_a();
            check_val($sformatf("fade_out_%0d", i), 32'(bright_a), 32'(15 - i));
            if (i == 3) begin
                // request while busy: must be ignored entirely
                req_a = 1; level_a = 2'd3;
                step_clk();
                req_a = 0;
                step_clk();
                check_val("busy_req_no_err", 32'(req_err_cnt_a), 32'd0);
            end
            if (i == 8) begin
                step_clk();
                check_val("scale_b7", 32'(rgb_out_a), 32'h742);
                blank_a = 0;
                step_clk();
                check_val("blank_zero", 32'(rgb_out_a), 32'h000);
                blank_a = 1;
            end
            if (i == 12) begin
                step_clk();
                check_val("scale_b3", 32'(rgb_out_a), 32'h321);
            end
            if (i < 15) check_val($sformatf("pal_hold_%0d", i), 32'(pal_sel_a), 32'd0);
        end
        check_val("swap_pending_pal", 32'(pal_sel_a), 32'd0);
        step_clk();
        check_val("swap_pal_sel",  32'(pal_sel_a), 32'd2);
        check_val("swap_busy",     32'(busy_a),    32'd1);
        check_val("scale_b0",      32'(rgb_out_a), 32'h000);

        for (int i = 1; i <= 15; i++) begin
            tick_a();
            check_val($sformatf("fade_in_%0d", i), 32'(bright_a), 32'(i));
            if (i == 15) check_val("done_on_finish", 32'(done_a), 32'd1);
        end
        check_val("finish_busy", 32'(busy_a), 32'd0);
        step_clk();
        step_clk();
        check_val("done_pulses",  32'(done_cnt_a), 32'd1);
        check_val("final_pal",    32'(pal_sel_a),  32'd2);
        check_val("full_bright",  32'(rgb_out_a),  32'hF84);

        // ---------------- instance b: out-of-range request ----------------
        req_b = 1; level_b = 3'd5;
        step_clk();
        req_b = 0;
        check_val("b_req_err_pulse", 32'(req_err_b), 32'd1);
        check_val("b_err_idle",      32'(busy_b),    32'd0);
        step_clk();
        check_val("b_req_err_clear", 32'(req_err_b), 32'd0);

        // ---------------- instance b: req with simultaneous frame tick ----------------
        req_b = 1; level_b = 3'd4; frame_tick_b = 1;
        step_clk();
        req_b = 0; frame_tick_b = 0;
        check_val("b_accept_busy", 32'(busy_b),   32'd1);
        tick_b();
        check_val("b_first_tick",  32'(bright_b), 32'd15);
        tick_b();
        check_val("b_first_step",  32'(bright_b), 32'd14);

        // ---------------- async reset mid fade-in ----------------
        req_a = 1; level_a = 2'd1;
        step_clk();
        req_a = 0;
        for (int i = 0; i < 15; i++) tick_a();
        step_clk();   // SWAP
        for (int i = 0; i < 5; i++) tick_a();
        check_val("pre_rst_bright", 32'(bright_a),  32'd5);
        check_val("pre_rst_pal",    32'(pal_sel_a), 32'd1);
        reset_n = 1'b0;
        #1;
        check_val("async_bright",  32'(bright_a),  32'd15);
        check_val("async_pal_sel", 32'(pal_sel_a), 32'd0);
        check_val("async_busy",    32'(busy_a),    32'd0);
        check_val("async_rgb_out", 32'(rgb_out_a), 32'h000);
        step_clk();
        reset_n = 1'b1;
        step_clk();
        check_val("post_rst_idle", 32'(busy_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
